// File: rtl/mat_core_switch.sv
// Rendezvous crossbar: a posted send and a posted receive that name each other move one vector in one cycle.
// Define SWITCH_LOOPBACK_EN to let a core send to and receive from itself.
module mat_core_switch #(
  parameter int CORE_SIZE = 2,
  parameter int WIDTH = 16,
  parameter int DATA_BITS = 32,
  localparam int CORE_ADDR_SIZE = (CORE_SIZE > 1) ? $clog2(CORE_SIZE) : 1
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic [CORE_SIZE-1:0]                            send_ready,
  input  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]        send_core_idx,
  input  logic [CORE_SIZE-1:0][WIDTH-1:0][DATA_BITS-1:0]  send_data,
  output logic [CORE_SIZE-1:0]                            send_ok,
  input  logic [CORE_SIZE-1:0]                            recv_request,
  input  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]        recv_core_idx,
  output logic [CORE_SIZE-1:0]                            recv_ready,
  output logic [CORE_SIZE-1:0][WIDTH-1:0][DATA_BITS-1:0]  recv_data
);

`ifdef SWITCH_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic [CORE_SIZE-1:0][CORE_SIZE-1:0]                match;      // [sender][receiver]
  logic [CORE_SIZE-1:0][CORE_SIZE-1:0]                match_t;    // [receiver][sender]
  logic [CORE_SIZE-1:0]                               send_hit;
  logic [CORE_SIZE-1:0]                               recv_hit;
  logic [CORE_SIZE-1:0]                               send_ok_reg;
  logic [CORE_SIZE-1:0]                               recv_ready_reg;
  logic [CORE_SIZE-1:0][WIDTH-1:0][DATA_BITS-1:0]     recv_data_reg;
  logic [CORE_SIZE-1:0][WIDTH-1:0][DATA_BITS-1:0]     recv_data_next;

  // A pair only matches when neither side is still showing its completion pulse,
  // which keeps a request held high across the pulse from transferring twice.
  for (genvar gi = 0; gi < CORE_SIZE; gi++) begin : g_send
    for (genvar gj = 0; gj < CORE_SIZE; gj++) begin : g_recv
      assign match[gi][gj] = (LOOPBACK || (gi != gj))
                          && send_ready[gi]
                          && (send_core_idx[gi] == CORE_ADDR_SIZE'(gj))
                          && recv_request[gj]
                          && (recv_core_idx[gj] == CORE_ADDR_SIZE'(gi))
                          && !send_ok_reg[gi]
                          && !recv_ready_reg[gj];
      assign match_t[gj][gi] = match[gi][gj];
    end
    assign send_hit[gi] = |match[gi];
  end

  for (genvar gi = 0; gi < CORE_SIZE; gi++) begin : g_recv_hit
    assign recv_hit[gi] = |match_t[gi];
  end

  // Matches are one-to-one, so at most one sender drives each receiver.
  always_comb begin
    recv_data_next = recv_data_reg;
    for (int r = 0; r < CORE_SIZE; r++) begin
      for (int s = 0; s < CORE_SIZE; s++) begin
        if (match[s][r]) begin
          recv_data_next[r] = send_data[s];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      send_ok_reg    <= '0;
      recv_ready_reg <= '0;
      recv_data_reg  <= '0;
    end else begin
      send_ok_reg    <= send_hit;
      recv_ready_reg <= recv_hit;
      recv_data_reg  <= recv_data_next;
    end
  end

  assign send_ok    = send_ok_reg;
  assign recv_ready = recv_ready_reg;
  assign recv_data  = recv_data_reg;

endmodule

// File: tb/tb_mat_core_switch.sv
// Directed bench for mat_core_switch: expected vectors are queued per receiver and popped on recv_ready.
module tb_mat_core_switch;
  localparam int CORE_SIZE = 2;
  localparam int WIDTH = 16;
  localparam int DATA_BITS = 32;
  localparam int CORE_ADDR_SIZE = 1;

  typedef logic [WIDTH-1:0][DATA_BITS-1:0] vec_t;

  logic                                            clock;
  logic                                            reset;
  logic [CORE_SIZE-1:0]                            send_ready;
  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]        send_core_idx;
  logic [CORE_SIZE-1:0][WIDTH-1:0][DATA_BITS-1:0]  send_data;
  logic [CORE_SIZE-1:0]                            send_ok;
  logic [CORE_SIZE-1:0]                            recv_request;
  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]        recv_core_idx;
  logic [CORE_SIZE-1:0]                            recv_ready;
  logic [CORE_SIZE-1:0][WIDTH-1:0][DATA_BITS-1:0]  recv_data;

  mat_core_switch #(
    .CORE_SIZE(CORE_SIZE),
    .WIDTH(WIDTH),
    .DATA_BITS(DATA_BITS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .send_ready(send_ready),
    .send_core_idx(send_core_idx),
    .send_data(send_data),
    .send_ok(send_ok),
    .recv_request(recv_request),
    .recv_core_idx(recv_core_idx),
    .recv_ready(recv_ready),
    .recv_data(recv_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int send_cnt [2];
  int recv_cnt [2];
  vec_t q0 [$];
  vec_t q1 [$];
  vec_t vec_a;
  vec_t vec_b;
  vec_t vec_t5;

  function automatic logic [31:0] int_to_float(input int n);
    int e;
    int mant;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    mant = (n - (1 << e)) << (23 - e);
    return {1'b0, 8'(127 + e), 23'(mant)};
  endfunction

  function automatic vec_t make_vec(input int base);
    vec_t v;
    for (int i = 0; i < WIDTH; i++) v[i] = int_to_float(base + i + 1);
    return v;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge, pulses scored against the queues.
  task automatic tick();
    vec_t e;
    @(posedge clock);
    #1;
    for (int s = 0; s < CORE_SIZE; s++) if (send_ok[s]) send_cnt[s]++;
    if (recv_ready[0]) begin
      recv_cnt[0]++;
      check("recv0_pulse_expected", 512'(q0.size() != 0), 512'(1));
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("recv_data0", recv_data[0], e);
      end
    end
    if (recv_ready[1]) begin
      recv_cnt[1]++;
      check("recv1_pulse_expected", 512'(q1.size() != 0), 512'(1));
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("recv_data1", recv_data[1], e);
      end
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < CORE_SIZE; i++) begin
      send_cnt[i] = 0;
      recv_cnt[i] = 0;
    end
  endtask

  task automatic drop_all();
    send_ready = '0;
    recv_request = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_a = make_vec(0);
    vec_b = make_vec(100);
    clear_counts();

    // Reset held two edges with a full swap posted
    reset = 1'b1;
    send_ready = 2'b11;
    send_core_idx[0] = 1'b1;
    send_core_idx[1] = 1'b0;
    send_data[0] = vec_a;
    send_data[1] = vec_b;
    recv_request = 2'b11;
    recv_core_idx[0] = 1'b1;
    recv_core_idx[1] = 1'b0;
    tick();
    tick();
    check("reset_send_ok", send_ok, 2'b00);
    check("reset_recv_ready", recv_ready, 2'b00);
    check("reset_recv_data0", recv_data[0], '0);
    check("reset_recv_data1", recv_data[1], '0);
    // First edge after release performs the pending swap
    reset = 1'b0;
    q0.push_back(vec_b);
    q1.push_back(vec_a);
    tick();
    check("release_send_ok", send_ok, 2'b11);
    check("release_recv_ready", recv_ready, 2'b11);
    drop_all();
    tick();
    check("release_clear", {send_ok, recv_ready}, 4'b0000);

    // Basic transfer 0 -> 1
    clear_counts();
    send_ready[0] = 1'b1;
    send_core_idx[0] = 1'b1;
    send_data[0] = vec_a;
    recv_request[1] = 1'b1;
    recv_core_idx[1] = 1'b0;
    q1.push_back(vec_a);
    tick();
    check("t2_send_ok", send_ok, 2'b01);
    check("t2_recv_ready", recv_ready, 2'b10);
    check("t2_word0", recv_data[1][0], 32'h3F800000);
    check("t2_word15", recv_data[1][15], 32'h41800000);
    drop_all();
    tick();
    check("t2_clear", {send_ok, recv_ready}, 4'b0000);
    check("t2_hold", recv_data[1], vec_a);

    // Late receive: send waits five cycles
    clear_counts();
    send_ready[0] = 1'b1;
    send_data[0] = vec_b;
    for (int i = 0; i < 5; i++) tick();
    check("t3_no_early_pulse", send_cnt[0] + recv_cnt[1], 0);
    recv_request[1] = 1'b1;
    q1.push_back(vec_b);
    tick();
    check("t3_send_ok", send_ok, 2'b01);
    check("t3_recv_ready", recv_ready, 2'b10);
    drop_all();
    tick();

    // Simultaneous swap
    clear_counts();
    send_data[0] = vec_a;
    send_data[1] = vec_b;
    send_ready = 2'b11;
    recv_request = 2'b11;
    q0.push_back(vec_b);
    q1.push_back(vec_a);
    tick();
    check("t4_send_ok", send_ok, 2'b11);
    check("t4_recv_ready", recv_ready, 2'b11);
    drop_all();
    tick();

    // Requests held six cycles: transfers on alternate cycles, new data each time
    clear_counts();
    send_ready[0] = 1'b1;
    recv_request[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if ((i % 2) == 0) begin
        for (int w = 0; w < WIDTH; w++) vec_t5[w] = $urandom;
        send_data[0] = vec_t5;
        q1.push_back(vec_t5);
      end
      tick();
    end
    check("t5_send_count", send_cnt[0], 3);
    check("t5_recv_count", recv_cnt[1], 3);
    drop_all();
    tick();

    // Cancelled send produces no pulse for a later lone receive
    clear_counts();
    send_ready[0] = 1'b1;
    tick();
    tick();
    send_ready[0] = 1'b0;
    recv_request[1] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("cancel_no_pulse", send_cnt[0] + recv_cnt[1], 0);
    drop_all();
    tick();

    // Self-addressed send/receive on core 0
    clear_counts();
    send_ready[0] = 1'b1;
    send_core_idx[0] = 1'b0;
    send_data[0] = vec_b;
    recv_request[0] = 1'b1;
    recv_core_idx[0] = 1'b0;
`ifdef SWITCH_LOOPBACK_EN
    q0.push_back(vec_b);
    tick();
    check("t6_loop_send_ok", send_ok, 2'b01);
    check("t6_loop_recv_ready", recv_ready, 2'b01);
`else
    for (int i = 0; i < 20; i++) tick();
    check("t6_no_loop_pulse", send_cnt[0] + recv_cnt[0], 0);
`endif
    drop_all();
    tick();

    // Reset on a match edge: no transfer, data cleared
    clear_counts();
    send_ready[0] = 1'b1;
    send_core_idx[0] = 1'b1;
    send_data[0] = vec_a;
    recv_request[1] = 1'b1;
    recv_core_idx[1] = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_match_pulses", {send_ok, recv_ready}, 4'b0000);
    check("rst_match_data1", recv_data[1], '0);
    reset = 1'b0;
    drop_all();
    tick();
    check("rst_match_after", send_cnt[0] + recv_cnt[1], 0);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
